// File: rtl/memory_arbiter.sv
// Round-robin arbiter granting one of N requesters access to a shared memory,
// with a bounded tenure and a one-cycle dead time between tenures.
module memory_arbiter #(
    parameter int unsigned N        = 5,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic [N-1:0]          i_Request,
    input  logic [N*ADDR_W-1:0]   i_Address,
    input  logic [N*DATA_W-1:0]   i_Write_Data,
    input  logic [N-1:0]          i_Write_Enable,
    input  logic [DATA_W-1:0]     i_Mem_Read_Data,
    output logic [N-1:0]          o_Grant,
    output logic [N-1:0]          o_Timeout,
    output logic [ADDR_W-1:0]     o_Mem_Address,
    output logic [DATA_W-1:0]     o_Mem_Write_Data,
    output logic                  o_Mem_Write_Enable,
    output logic [DATA_W-1:0]     o_Read_Data,
    output logic                  o_Busy
);

    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_State,   w_Next_State;
    logic [N-1:0]        r_Grant,   w_Next_Grant;
    logic [N-1:0]        r_Timeout, w_Next_Timeout;
    logic [HOLD_W-1:0]   r_Hold,    w_Next_Hold;
    logic [IDX_W-1:0]    r_Last,    w_Next_Last;
    logic [IDX_W-1:0]    r_Gidx,    w_Next_Gidx;

    logic                w_Win_Valid;
    logic [IDX_W-1:0]    w_Win_Idx;

    // (base + off) mod N for base < N and off <= N
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned s;
        s = int'(32'(base)) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search starting just after the last released index
    always_comb begin
        w_Win_Valid = 1'b0;
        w_Win_Idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (!w_Win_Valid && i_Request[wrap_idx(r_Last, i)]) begin
                w_Win_Valid = 1'b1;
                w_Win_Idx   = wrap_idx(r_Last, i);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State   <= S_IDLE;
            r_Grant   <= '0;
            r_Timeout <= '0;
            r_Hold    <= '0;
            r_Last    <= IDX_W'(N - 1);
            r_Gidx    <= '0;
        end else begin
            r_State   <= w_Next_State;
            r_Grant   <= w_Next_Grant;
            r_Timeout <= w_Next_Timeout;
            r_Hold    <= w_Next_Hold;
            r_Last    <= w_Next_Last;
            r_Gidx    <= w_Next_Gidx;
        end
    end

    // Next-state logic: arbitrate in IDLE, track tenure in GRANTED, one dead cycle in RELEASE
    always_comb begin
        w_Next_State   = r_State;
        w_Next_Grant   = r_Grant;
        w_Next_Timeout = '0;
        w_Next_Hold    = r_Hold;
        w_Next_Last    = r_Last;
        w_Next_Gidx    = r_Gidx;
        case (r_State)
            S_IDLE: begin
                w_Next_Grant = '0;
                if (w_Win_Valid) begin
                    w_Next_State = S_GRANTED;
                    w_Next_Grant = N'(1) << w_Win_Idx;
                    w_Next_Hold  = '0;
                    w_Next_Gidx  = w_Win_Idx;
                end
            end
            S_GRANTED: begin
                // A voluntary drop takes priority over the tenure limit, so no pulse then
                if (!i_Request[r_Gidx]) begin
                    w_Next_State = S_RELEASE;
                    w_Next_Grant = '0;
                    w_Next_Last  = r_Gidx;
                end else if (r_Hold == HOLD_W'(MAX_HOLD - 1)) begin
                    w_Next_State   = S_RELEASE;
                    w_Next_Grant   = '0;
                    w_Next_Timeout = N'(1) << r_Gidx;
                    w_Next_Last    = r_Gidx;
                end else begin
                    w_Next_Hold = r_Hold + HOLD_W'(1);
                end
            end
            S_RELEASE: begin
                w_Next_State = S_IDLE;
                w_Next_Grant = '0;
            end
            default: begin
                w_Next_State = S_IDLE;
                w_Next_Grant = '0;
            end
        endcase
    end

    // Memory-side mux: only the granted requester reaches memory, and only while GRANTED
    always_comb begin
        o_Mem_Address      = '0;
        o_Mem_Write_Data   = '0;
        o_Mem_Write_Enable = 1'b0;
        if (r_State == S_GRANTED) begin
            for (int k = 0; k < int'(N); k++) begin
                if (r_Gidx == IDX_W'(k)) begin
                    o_Mem_Address      = i_Address[k*ADDR_W +: ADDR_W];
                    o_Mem_Write_Data   = i_Write_Data[k*DATA_W +: DATA_W];
                    o_Mem_Write_Enable = i_Write_Enable[k] & i_Request[k];
                end
            end
        end
    end

    assign o_Grant     = r_Grant;
    assign o_Timeout   = r_Timeout;
    assign o_Read_Data = i_Mem_Read_Data;
    assign o_Busy      = (r_State != S_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (default parameters).
module tb_memory_arbiter;

    localparam int unsigned N        = 5;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_HOLD = 64;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0]          req;
    logic [N*ADDR_W-1:0]   addr;
    logic [N*DATA_W-1:0]   wdata;
    logic [N-1:0]          we;
    logic [DATA_W-1:0]     mem_rdata;
    logic [N-1:0]          grant;
    logic [N-1:0]          timeout;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic [DATA_W-1:0]     rdata;
    logic                  busy;

    int checks;
    int errors;

    memory_arbiter #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_Clock            (clk),
        .i_Reset_n          (rst_n),
        .i_Request          (req),
        .i_Address          (addr),
        .i_Write_Data       (wdata),
        .i_Write_Enable     (we),
        .i_Mem_Read_Data    (mem_rdata),
        .o_Grant            (grant),
        .o_Timeout          (timeout),
        .o_Mem_Address      (mem_addr),
        .o_Mem_Write_Data   (mem_wdata),
        .o_Mem_Write_Enable (mem_we),
        .o_Read_Data        (rdata),
        .o_Busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        addr      = '0;
        wdata     = '0;
        we        = '0;
        mem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant got %b want %b", grant, 5'b00000); end
        checks++;
        if (timeout !== 5'b00000) begin errors++; $display("FAIL reset_timeout got %b want %b", timeout, 5'b00000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem got we=%b addr=%h data=%h want 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        // No requests: stays idle
        repeat (3) tick();
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_req got grant=%b busy=%b want 00000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 5'b00001;
        tick();
        checks++;
        if (grant !== 5'b00001) begin errors++; $display("FAIL single_grant got %b want %b", grant, 5'b00001); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        req = 5'b00000;
        tick();
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b1 || timeout !== 5'b00000) begin
            errors++; $display("FAIL single_release got grant=%b busy=%b to=%b want 00000/1/00000", grant, busy, timeout);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int order [6];
        logic [N-1:0] exp;
        int wait_n;
        order = '{0, 1, 2, 3, 4, 0};
        do_reset();
        req = 5'b11111;
        for (int t = 0; t < 6; t++) begin
            exp = 5'b00001 << order[t];
            wait_n = 0;
            while (grant === 5'b00000 && wait_n < 10) begin
                tick();
                wait_n++;
            end
            checks++;
            if (grant !== exp) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", t, grant, exp); end
            tick();
            tick();
            checks++;
            if (grant !== exp) begin errors++; $display("FAIL rr_hold[%0d] got %b want %b", t, grant, exp); end
            req[order[t]] = 1'b0;
            tick();
            checks++;
            if (grant !== 5'b00000 || busy !== 1'b1 || timeout !== 5'b00000) begin
                errors++; $display("FAIL rr_release[%0d] got grant=%b busy=%b to=%b want 00000/1/00000", t, grant, busy, timeout);
            end
            req[order[t]] = 1'b1;
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req = 5'b00100;
        tick();
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (grant === 5'b00100) cnt++;
            else break;
        end
        checks++;
        if (cnt != 64) begin errors++; $display("FAIL to_hold_cycles got %0d want %0d", cnt, 64); end
        checks++;
        if (grant !== 5'b00000 || timeout !== 5'b00100 || busy !== 1'b1) begin
            errors++; $display("FAIL to_pulse got grant=%b to=%b busy=%b want 00000/00100/1", grant, timeout, busy);
        end
        tick();
        checks++;
        if (timeout !== 5'b00000 || grant !== 5'b00000 || busy !== 1'b0) begin
            errors++; $display("FAIL to_pulse_end got to=%b grant=%b busy=%b want 00000/00000/0", timeout, grant, busy);
        end
        tick();
        checks++;
        if (grant !== 5'b00100) begin errors++; $display("FAIL to_regrant got %b want %b", grant, 5'b00100); end
        tick();
        req = 5'b00000;
        tick();
        checks++;
        if (grant !== 5'b00000 || timeout !== 5'b00000) begin
            errors++; $display("FAIL to_final_release got grant=%b to=%b want 00000/00000", grant, timeout);
        end
        tick();
    endtask

    task automatic test_write_path();
        do_reset();
        addr[3*ADDR_W +: ADDR_W]  = 16'h00A5;
        wdata[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
        we[3]                     = 1'b1;
        addr[1*ADDR_W +: ADDR_W]  = 16'h1234;
        wdata[1*DATA_W +: DATA_W] = 32'hCAFEF00D;
        we[1]                     = 1'b1;
        req = 5'b01000;
        #1;
        checks++;
        if (mem_addr !== 16'h0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL wr_idle_mem got addr=%h we=%b want 0000/0", mem_addr, mem_we);
        end
        tick();
        checks++;
        if (grant !== 5'b01000) begin errors++; $display("FAIL wr_grant got %b want %b", grant, 5'b01000); end
        checks++;
        if (mem_addr !== 16'h00A5 || mem_wdata !== 32'hDEADBEEF || mem_we !== 1'b1) begin
            errors++; $display("FAIL wr_mem got addr=%h data=%h we=%b want 00a5/deadbeef/1", mem_addr, mem_wdata, mem_we);
        end
        mem_rdata = 32'h13579BDF;
        req[1]    = 1'b1;
        tick();
        checks++;
        if (rdata !== 32'h13579BDF) begin errors++; $display("FAIL wr_rdata got %h want %h", rdata, 32'h13579BDF); end
        checks++;
        if (grant !== 5'b01000 || mem_addr !== 16'h00A5 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_no_steal got grant=%b addr=%h data=%h want 01000/00a5/deadbeef", grant, mem_addr, mem_wdata);
        end
        we[3] = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_follow got %b want 0", mem_we); end
        we[3]  = 1'b1;
        req[3] = 1'b0;
        tick();
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL wr_release_mem got addr=%h data=%h we=%b want 0/0/0", mem_addr, mem_wdata, mem_we);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        we[3] = 1'b1;
        req   = 5'b01000;
        tick();
        checks++;
        if (grant !== 5'b01000 || mem_we !== 1'b1) begin
            errors++; $display("FAIL rmg_pre got grant=%b we=%b want 01000/1", grant, mem_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 5'b00000 || mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmg_async got grant=%b we=%b busy=%b want 00000/0/0", grant, mem_we, busy);
        end
        rst_n = 1'b1;
        req   = 5'b10010;
        tick();
        checks++;
        if (grant !== 5'b00010) begin errors++; $display("FAIL rmg_first got %b want %b", grant, 5'b00010); end
        req = '0;
        we  = '0;
        repeat (3) tick();
    endtask

    task automatic test_drop_at_limit();
        do_reset();
        req = 5'b00100;
        tick();
        repeat (MAX_HOLD - 1) tick();
        checks++;
        if (grant !== 5'b00100) begin errors++; $display("FAIL dal_last_cycle got %b want %b", grant, 5'b00100); end
        req = 5'b00000;
        tick();
        checks++;
        if (grant !== 5'b00000 || timeout !== 5'b00000 || busy !== 1'b1) begin
            errors++; $display("FAIL dal_release got grant=%b to=%b busy=%b want 00000/00000/1", grant, timeout, busy);
        end
        tick();
        checks++;
        if (timeout !== 5'b00000 || busy !== 1'b0) begin
            errors++; $display("FAIL dal_after got to=%b busy=%b want 00000/0", timeout, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        addr   = '0;
        wdata  = '0;
        we     = '0;
        mem_rdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_write_path();
        test_reset_mid_grant();
        test_drop_at_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter N, default 5, number of requesters; index 0 = main control unit, 1..N-1 = processors.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DATA_W, default 32, memory data width.
REQ-004 Parameter MAX_HOLD, default 64, maximum consecutive grant cycles per tenure (MAX_HOLD >= 2).
REQ-005 i_Clock  input  1  single clock; all state changes on rising edge.
REQ-006 i_Reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_Request  input  N  level request per requester.
REQ-008 i_Address  input  N*ADDR_W  packed; requester k at [k*ADDR_W +: ADDR_W].
REQ-009 i_Write_Data  input  N*DATA_W  packed; requester k at [k*DATA_W +: DATA_W].
REQ-010 i_Write_Enable  input  N  per-requester write strobe.
REQ-011 i_Mem_Read_Data  input  DATA_W  read data from shared memory.
REQ-012 o_Grant  output  N  registered, one-hot or all-zero.
REQ-013 o_Timeout  output  N  registered one-cycle pulse to a requester whose grant was revoked.
REQ-014 o_Mem_Address  output  ADDR_W  address of granted requester.
REQ-015 o_Mem_Write_Data  output  DATA_W  write data of granted requester.
REQ-016 o_Mem_Write_Enable  output  1  write strobe to memory.
REQ-017 o_Read_Data  output  DATA_W  i_Mem_Read_Data passed through combinationally; meaningful only to granted requester.
REQ-018 o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, GRANTED, RELEASE.
REQ-020 IDLE: if any i_Request bit high, winner = first high bit searching from (r_Last+1) mod N upward with wrap; o_Grant[winner] set at that edge, state -> GRANTED, hold counter cleared.
REQ-021 Latency: request high before edge k, no contention -> o_Grant high after edge k (1 cycle).
REQ-022 IDLE with no requests: stay IDLE, o_Grant = 0.
REQ-023 GRANTED: hold counter increments each cycle; memory outputs driven combinationally from the granted requester's i_Address / i_Write_Data.
REQ-024 o_Mem_Write_Enable = i_Write_Enable[g] AND i_Request[g] only in GRANTED; 0 in IDLE and RELEASE.
REQ-025 No grant: o_Mem_Address = 0, o_Mem_Write_Data = 0, o_Mem_Write_Enable = 0.
REQ-026 Granted requester deasserts i_Request: o_Grant cleared at next edge, r_Last = g, state -> RELEASE, no timeout pulse.
REQ-027 Hold counter reaches MAX_HOLD-1 with i_Request[g] still high: o_Grant cleared, o_Timeout[g] pulsed one cycle, r_Last = g, state -> RELEASE.
REQ-028 Request deassert and timeout on same cycle: treated as normal release (REQ-026), no pulse.
REQ-029 RELEASE: exactly one dead cycle, o_Grant = 0, then IDLE; arbitration resumes in IDLE.
REQ-030 Revoked requester keeping i_Request high re-competes normally; round-robin places it last.
REQ-031 Requests from other indexes during GRANTED are not queued; only levels present in IDLE are evaluated.
REQ-032 o_Grant never has more than one bit set; no grant ever issued in RELEASE.
REQ-033 Worst-case wait for a continuously requesting index: (N-1)*(MAX_HOLD+2) + 2 cycles.

Reset
REQ-034 i_Reset_n low asynchronously forces state IDLE, o_Grant = 0, o_Timeout = 0, hold counter = 0, r_Last = N-1 (index 0 wins first arbitration).
REQ-035 Reset asserted mid-grant: o_Grant and o_Mem_Write_Enable drop to 0 without waiting for a clock edge.
REQ-036 After reset release, first arbitration occurs at the first rising edge with i_Reset_n high.

Verification
REQ-037 Reset, then i_Request = 5'b00001 -> o_Grant = 5'b00001 one cycle later; drop request -> o_Grant = 0 next edge, o_Busy high one more cycle (RELEASE), then low.
REQ-038 i_Request = 5'b11111 held, each requester drops after 3 granted cycles -> grant order 0,1,2,3,4,0; 1 dead cycle between tenures.
REQ-039 Requester 2 alone holds request 70 cycles, MAX_HOLD = 64 -> grant for 64 cycles, o_Timeout = 5'b00100 for one cycle, re-granted after RELEASE + IDLE.
REQ-040 Granted requester 3 with i_Write_Enable[3] = 1, address 16'h00A5, data 32'hDEADBEEF -> memory sees exactly those values with o_Mem_Write_Enable = 1; requester 1's signals never reach memory.
REQ-041 i_Reset_n pulled low mid-GRANTED -> o_Grant = 0 and o_Mem_Write_Enable = 0 same cycle; after release with i_Request = 5'b10010 -> index 1 granted first.
REQ-042 Request drop on the cycle the counter hits MAX_HOLD-1 -> no o_Timeout pulse; normal release.
